// File: rtl/draw_sequencer.sv
// Letter update sequencer for the Morse display: runs the black clear, then plots a scaled
// 5x7 glyph at a fixed origin. Sole driver of the VGA adapter's x/y/colour/plot inputs.
module draw_sequencer #(
    parameter logic [7:0]  ORIGIN_X     = 8'd10,
    parameter logic [6:0]  ORIGIN_Y     = 7'd5,
    parameter int unsigned SCALE        = 4,
    parameter logic [2:0]  FG_COLOUR    = 3'b111,
    parameter int unsigned CLEAR_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       letter_valid,
    input  logic [4:0] letter_code,
    output logic       letter_ready,
    output logic       blk_signal,
    input  logic [7:0] blk_x,
    input  logic [6:0] blk_y,
    input  logic       blk_finished,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned     ClrW    = $clog2(CLEAR_CYCLES + 1);
    localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);
    localparam logic [ClrW-1:0] ClrOne  = ClrW'(1);
    localparam logic [2:0]      SubLast = 3'(SCALE - 1);
    localparam logic [9:0]      Scale10 = 10'(SCALE);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StGlyph,
        StDone
    } state_e;

    state_e          state_q;
    logic            ready_q;
    logic            blk_sig_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      vga_colour_q;
    logic            vga_plot_q;
    logic [4:0]      code_q;
    logic [ClrW-1:0] clr_cnt_q;

    logic [2:0] row_q, sy_q, col_q, sx_q;
    logic [2:0] row_d, sy_d, col_d, sx_d;
    logic       last_pos;

    logic [34:0] glyph;
    logic [5:0]  bit_idx;
    logic        glyph_bit;
    logic [7:0]  glyph_x;
    logic [6:0]  glyph_y;

    // Glyph rows packed top row first; within a row the MSB is the leftmost dot.
    always_comb begin
        glyph = '0;
        case (code_q)
            5'd0:  glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
            5'd1:  glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
            5'd2:  glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
            5'd3:  glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
            5'd4:  glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
            5'd5:  glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
            5'd6:  glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
            5'd7:  glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
            5'd8:  glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
            5'd9:  glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
            5'd10: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
            5'd11: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
            5'd12: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
            5'd13: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
            5'd14: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
            5'd15: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
            5'd16: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
            5'd17: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
            5'd18: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
            5'd19: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
            5'd20: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
            5'd21: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
            5'd22: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
            5'd23: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
            5'd24: glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
            5'd25: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
            default: glyph = '0;
        endcase
    end

    always_comb begin
        bit_idx   = 6'd34 - ({3'd0, row_q} * 6'd5) - {3'd0, col_q};
        glyph_bit = glyph[bit_idx];
        // Sums are formed at 10 bits and wrap into the adapter's coordinate range.
        glyph_x   = 8'({2'b00, ORIGIN_X} + {7'd0, col_q} * Scale10 + {7'd0, sx_q});
        glyph_y   = 7'({3'b000, ORIGIN_Y} + {7'd0, row_q} * Scale10 + {7'd0, sy_q});
    end

    // Scan order: row, sub-row, column, sub-column (innermost).
    always_comb begin
        sx_d  = sx_q + 3'd1;
        col_d = col_q;
        sy_d  = sy_q;
        row_d = row_q;
        if (sx_q == SubLast) begin
            sx_d = 3'd0;
            if (col_q == 3'd4) begin
                col_d = 3'd0;
                if (sy_q == SubLast) begin
                    sy_d  = 3'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    sy_d = sy_q + 3'd1;
                end
            end else begin
                col_d = col_q + 3'd1;
            end
        end
        last_pos = (row_q == 3'd6) && (sy_q == SubLast) && (col_q == 3'd4) && (sx_q == SubLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            blk_sig_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            code_q       <= '0;
            clr_cnt_q    <= '0;
            row_q        <= '0;
            sy_q         <= '0;
            col_q        <= '0;
            sx_q         <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    vga_plot_q <= 1'b0;
                    if (letter_valid) begin
                        code_q    <= letter_code;
                        clr_cnt_q <= '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        blk_sig_q <= 1'b1;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    vga_x_q      <= blk_x;
                    vga_y_q      <= blk_y;
                    vga_colour_q <= 3'b000;
                    clr_cnt_q    <= clr_cnt_q + ClrOne;
                    // The clear stage's coordinate in the exit cycle is not a pixel to paint.
                    if (blk_finished || (clr_cnt_q == ClrLast)) begin
                        vga_plot_q <= 1'b0;
                        blk_sig_q  <= 1'b0;
                        row_q      <= '0;
                        sy_q       <= '0;
                        col_q      <= '0;
                        sx_q       <= '0;
                        state_q    <= StGlyph;
                    end else begin
                        vga_plot_q <= 1'b1;
                    end
                end
                StGlyph: begin
                    vga_x_q      <= glyph_x;
                    vga_y_q      <= glyph_y;
                    vga_colour_q <= FG_COLOUR;
                    vga_plot_q   <= glyph_bit;
                    row_q        <= row_d;
                    sy_q         <= sy_d;
                    col_q        <= col_d;
                    sx_q         <= sx_d;
                    if (last_pos) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    vga_plot_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign letter_ready = ready_q;
    assign blk_signal   = blk_sig_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_colour   = vga_colour_q;
    assign vga_plot     = vga_plot_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomised bench for draw_sequencer: a clear-stage stand-in plus a pixel-list model of the
// glyph drawing, checked for a default instance and a small wrapping instance.
module tb_draw_sequencer;

    localparam int S   = 4;
    localparam int OX  = 10;
    localparam int OY  = 5;
    localparam int CLR = 16384;
    localparam logic [2:0] FG = 3'b111;
    localparam int BS   = 1;
    localparam int BOX  = 250;
    localparam int BOY  = 124;
    localparam int BCLR = 8;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset;
    logic       letter_valid;
    logic [4:0] letter_code;
    logic       letter_ready, blk_signal, blk_finished;
    logic [7:0] blk_x;
    logic [6:0] blk_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    logic       b_valid;
    logic [4:0] b_code;
    logic       b_ready, b_blk_signal, b_blk_finished;
    logic [7:0] b_blk_x;
    logic [6:0] b_blk_y;
    logic [7:0] b_vga_x;
    logic [6:0] b_vga_y;
    logic [2:0] b_colour;
    logic       b_plot, b_busy, b_done;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];
    logic [14:0] act_q[$];

    draw_sequencer dut (
        .clk(clk), .reset(reset), .letter_valid(letter_valid), .letter_code(letter_code),
        .letter_ready(letter_ready), .blk_signal(blk_signal), .blk_x(blk_x), .blk_y(blk_y),
        .blk_finished(blk_finished), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    draw_sequencer #(
        .ORIGIN_X(8'd250), .ORIGIN_Y(7'd124), .SCALE(BS), .FG_COLOUR(3'b111),
        .CLEAR_CYCLES(BCLR)
    ) dut_b (
        .clk(clk), .reset(reset), .letter_valid(b_valid), .letter_code(b_code),
        .letter_ready(b_ready), .blk_signal(b_blk_signal), .blk_x(b_blk_x), .blk_y(b_blk_y),
        .blk_finished(b_blk_finished), .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_colour),
        .vga_plot(b_plot), .busy(b_busy), .done(b_done)
    );

    function automatic logic [4:0] model_row(input logic [4:0] code, input int r);
        if (code == 5'd4) begin
            if (r == 0 || r == 6) return 5'b11111;
            if (r == 3) return 5'b11110;
            return 5'b10000;
        end
        if (code == 5'd19) return (r == 0) ? 5'b11111 : 5'b00100;
        return 5'b00000;
    endfunction

    // Expected foreground pixels, in drawing order, as {x, y}.
    task automatic build_model(input logic [4:0] code, input int s, input int ox, input int oy);
        logic [4:0] row;
        exp_q.delete();
        for (int r = 0; r < 7; r++) begin
            row = model_row(code, r);
            for (int sy = 0; sy < s; sy++)
                for (int c = 0; c < 5; c++)
                    for (int sx = 0; sx < s; sx++)
                        if (row[4-c])
                            exp_q.push_back({8'((ox + c * s + sx) % 256),
                                             7'((oy + r * s + sy) % 128)});
        end
    endtask

    task automatic run_letter(input logic [4:0] code, input int fin_after, input bit hold_valid,
                              input bit expect_quick, output int n_fg);
        int wait_n = 0;
        bit got = 0;
        int clr_len = 0, g = -1, done_at = -1, n_black = 0;
        int bad_black = 0, bad_status = 0, bad_fg = 0, bad_pos = 0, clr_exp;
        logic [7:0] prev_bx = '0;
        logic [6:0] prev_by = '0;
        while (!got && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
            blk_finished = 1'b0;
            if (letter_ready === 1'b1) begin
                letter_valid = 1'b1;
                letter_code  = code;
                got = 1;
            end else begin
                letter_valid = hold_valid;
                letter_code  = (code == 5'd4) ? 5'd19 : 5'd4;
            end
        end
        checks++;
        if (!got || (expect_quick && wait_n != 1)) begin
            errors++;
            $display("FAIL accept_%0d: waited %0d cycles (accepted=%0d) want %0s", code, wait_n,
                     got, expect_quick ? "1" : "<20");
        end
        build_model(code, S, OX, OY);
        act_q.delete();
        for (int cyc = 0; cyc < CLR + 35 * S * S + 50 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && blk_signal !== 1'b1) bad_status++;
            if (blk_signal === 1'b1) begin
                clr_len++;
                if (busy !== 1'b1 || letter_ready !== 1'b0 || done !== 1'b0) bad_status++;
                if (vga_plot === 1'b1 && vga_colour === 3'b000) n_black++;
                if (clr_len == 1) begin
                    if (vga_plot !== 1'b0) bad_black++;
                end else if (vga_plot !== 1'b1 || vga_colour !== 3'b000 || vga_x !== prev_bx ||
                             vga_y !== prev_by) begin
                    bad_black++;
                end
            end else begin
                g++;
                if (g == 0 && vga_plot !== 1'b0) bad_black++;
                if (g >= 1 && vga_plot === 1'b1) begin
                    act_q.push_back({vga_x, vga_y});
                    if (vga_colour !== FG) bad_fg++;
                end
                if (done === 1'b1) done_at = g;
                else if (busy !== 1'b1 || letter_ready !== 1'b0) bad_status++;
            end
            blk_x   = 8'($urandom);
            blk_y   = 7'($urandom);
            prev_bx = blk_x;
            prev_by = blk_y;
            blk_finished = (blk_signal === 1'b1) && (fin_after != 0) && (clr_len == fin_after);
            letter_valid = hold_valid;
            letter_code  = (code == 5'd4) ? 5'd19 : 5'd4;
        end
        clr_exp = (fin_after != 0) ? fin_after : CLR;
        checks++;
        if (clr_len != clr_exp) begin
            errors++;
            $display("FAIL clear_len_%0d: got %0d want %0d", code, clr_len, clr_exp);
        end
        checks++;
        if (n_black != clr_exp - 1 || bad_black != 0) begin
            errors++;
            $display("FAIL black_plots_%0d: got %0d (bad %0d) want %0d", code, n_black, bad_black,
                     clr_exp - 1);
        end
        checks++;
        if (done_at != 35 * S * S) begin
            errors++;
            $display("FAIL done_time_%0d: got %0d want %0d", code, done_at, 35 * S * S);
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (act_q[i] !== exp_q[i]) bad_pos++;
        checks++;
        if (act_q.size() != exp_q.size() || bad_pos != 0 || bad_fg != 0) begin
            errors++;
            $display("FAIL glyph_pixels_%0d: got %0d plots (%0d misplaced, %0d bad colour) want %0d",
                     code, act_q.size(), bad_pos, bad_fg, exp_q.size());
        end
        checks++;
        if (bad_status != 0) begin
            errors++;
            $display("FAIL status_%0d: got %0d bad busy/ready cycles want 0", code, bad_status);
        end
        n_fg = act_q.size();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        letter_valid = 1'b0; letter_code = '0;
        blk_x = '0; blk_y = '0; blk_finished = 1'b0;
        b_valid = 1'b0; b_code = '0; b_blk_x = '0; b_blk_y = '0; b_blk_finished = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({letter_ready, blk_signal, busy, done, vga_plot, vga_x, vga_y, vga_colour} !==
            {1'b1, 4'b0000, 8'd0, 7'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got %b want 1 then zeros",
                     {letter_ready, blk_signal, busy, done, vga_plot, vga_x, vga_y, vga_colour});
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_glyph();
        int n = 0, dones = 0, bad_idle = 0;
        blk_finished = 1'b1;
        @(negedge clk);
        letter_valid = 1'b1; letter_code = 5'd4;
        @(negedge clk);
        letter_valid = 1'b0;
        while (!(busy === 1'b1 && blk_signal === 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL reach_glyph: got no GLYPH within %0d cycles want <50", n);
        end
        repeat (100) @(negedge clk);
        blk_finished = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({letter_ready, vga_plot, blk_signal, busy, done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_mid_glyph: got %b want 10000",
                     {letter_ready, vga_plot, blk_signal, busy, done});
        end
        reset = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (letter_ready !== 1'b1 || vga_plot !== 1'b0 || busy !== 1'b0) bad_idle++;
        end
        checks++;
        if (dones != 0 || bad_idle != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d done, %0d non-idle cycles want 0 0",
                     dones, bad_idle);
        end
    endtask

    task automatic test_letter_e();
        int n;
        run_letter(5'd4, 100, 1'b0, 1'b0, n);
        checks++;
        if (n != 288) begin
            errors++;
            $display("FAIL e_plot_count: got %0d want 288", n);
        end
        checks++;
        if (n == 0 || act_q[0] !== {8'd10, 7'd5} || act_q[n-1] !== {8'd29, 7'd32}) begin
            errors++;
            $display("FAIL e_first_last: got %h %h want %h %h", (n > 0) ? act_q[0] : 15'h0,
                     (n > 0) ? act_q[n-1] : 15'h0, {8'd10, 7'd5}, {8'd29, 7'd32});
        end
    endtask

    task automatic test_letter_t();
        int n, out_x = 0;
        run_letter(5'd19, 0, 1'b0, 1'b0, n);
        foreach (act_q[i])
            if (act_q[i][14:7] < 8'd10 || act_q[i][14:7] > 8'd29) out_x++;
        checks++;
        if (n != 176 || out_x != 0) begin
            errors++;
            $display("FAIL t_plots: got %0d plots, %0d outside x 10..29 want 176 0", n, out_x);
        end
    endtask

    task automatic test_blank();
        int n;
        run_letter(5'd26, 37, 1'b0, 1'b0, n);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL space_plots: got %0d want 0", n);
        end
        run_letter(5'd31, 1, 1'b0, 1'b0, n);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL blank31_plots: got %0d want 0", n);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pick [4];
        logic [4:0] code;
        int n;
        pick[0] = 5'd4; pick[1] = 5'd19; pick[2] = 5'd26; pick[3] = 5'd31;
        for (int i = 0; i < 6; i++) begin
            code = (i % 2 == 0) ? pick[$urandom_range(0, 1)] : pick[$urandom_range(2, 3)];
            run_letter(code, int'($urandom_range(1, 40)), 1'b1, i != 0, n);
        end
        letter_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int n254 = 0, bad_pos = 0, unk = 0, done_seen = 0;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ready: got %b want 1", b_ready);
        end
        b_valid = 1'b1; b_code = 5'd4;
        @(negedge clk);
        b_valid = 1'b0;
        build_model(5'd4, BS, BOX, BOY);
        act_q.delete();
        for (int cyc = 0; cyc < BCLR + 35 * BS * BS + 20 && done_seen == 0; cyc++) begin
            @(negedge clk);
            if ($isunknown({b_vga_x, b_vga_y, b_colour, b_plot})) unk++;
            if (b_plot === 1'b1 && b_colour === 3'b111) act_q.push_back({b_vga_x, b_vga_y});
            if (b_done === 1'b1) done_seen = 1;
        end
        foreach (act_q[i]) if (act_q[i][14:7] == 8'd254) n254++;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (act_q[i] !== exp_q[i]) bad_pos++;
        checks++;
        if (act_q.size() != exp_q.size() || bad_pos != 0 || done_seen != 1) begin
            errors++;
            $display("FAIL wrap_pixels: got %0d plots (%0d misplaced, done %0d) want %0d done 1",
                     act_q.size(), bad_pos, done_seen, exp_q.size());
        end
        checks++;
        if (n254 != 2 || unk != 0) begin
            errors++;
            $display("FAIL wrap_col4: got %0d at x=254 (%0d unknown) want 2 0", n254, unk);
        end
        checks++;
        if (act_q.size() == 0 || act_q[act_q.size()-1] !== {8'd254, 7'd2}) begin
            errors++;
            $display("FAIL wrap_last: got %h want %h",
                     (act_q.size() > 0) ? act_q[act_q.size()-1] : 15'h0, {8'd254, 7'd2});
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_glyph();
        test_letter_e();
        test_letter_t();
        test_blank();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Sequences one on-screen letter update for the Morse coder display, and feeds the VGA adapter directly.
- On each decoded letter it first runs the black-clear stage. It passes that stage's coordinates through to the adapter until the clear completes.
- It then draws the letter from an internal 5x7 glyph ROM, scaled by SCALE, at a fixed origin.
- It is the sole driver of the adapter's x/y/colour/plot inputs.

Parameters:
- ORIGIN_X, 10, left pixel column of the glyph box (8-bit).
- ORIGIN_Y, 5, top pixel row of the glyph box (7-bit).
- SCALE, 4, side length in pixels of each glyph dot; legal values 1..8.
- FG_COLOUR, 3'b111, colour of set glyph dots.
- CLEAR_CYCLES, 16384, maximum clear-phase length in clocks (timeout).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- letter_valid  in  1  letter_code is valid this cycle
- letter_code  in  5  0..25 = A..Z, 26 = space, 27..31 = blank
- letter_ready  out  1  high only in IDLE; handshake completes when valid && ready
- blk_signal  out  1  enable to the clear stage
- blk_x  in  8  x coordinate from the clear stage
- blk_y  in  7  y coordinate from the clear stage
- blk_finished  in  1  clear-stage completion flag
- vga_x  out  8  adapter x coordinate
- vga_y  out  7  adapter y coordinate
- vga_colour  out  3  adapter colour
- vga_plot  out  1  adapter write enable
- busy  out  1  high in CLEAR and GLYPH
- done  out  1  one-cycle pulse at the end of each letter

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE; letter_ready=1; all other outputs 0; counters 0.
  - Reset in any state aborts the operation immediately; no done pulse is produced.
- IDLE:
  - letter_ready=1, vga_plot=0.
  - On letter_valid: latch letter_code, clear the cycle counter, go to CLEAR.
- CLEAR:
  - blk_signal=1, vga_colour=000, vga_x=blk_x, vga_y=blk_y (registered, 1-cycle latency).
  - vga_plot=0 on the first CLEAR cycle, 1 on every later CLEAR cycle.
  - Exit to GLYPH when blk_finished=1, or when the cycle counter reaches CLEAR_CYCLES-1, whichever comes first.
  - blk_signal drops to 0 in the cycle GLYPH is entered.
- GLYPH:
  - Walks nested counters: row r 0..6 (outer), sub-row sy 0..SCALE-1, column c 0..4, sub-column sx 0..SCALE-1 (inner).
  - Exactly one position per clock; total 35*SCALE*SCALE cycles (560 at default).
  - vga_x = ORIGIN_X + c*SCALE + sx; vga_y = ORIGIN_Y + r*SCALE + sy. Computed at 10 bits, truncated to 8/7 bits (wrap, no saturation).
  - vga_colour=FG_COLOUR.
  - vga_plot = glyph bit (row r, bit 4-c; bit4 = leftmost, row0 = top). Registered, so the last position's plot occurs in the DONE cycle.
  - After the last position, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Glyph ROM:
  - Combinational case on the latched code.
  - Codes 26..31: all rows 00000, so no plots but full GLYPH duration.
  - E = 11111,10000,10000,11110,10000,10000,11111.
  - T = 11111,00100 x6.
- Handshake and outputs:
  - letter_valid while busy is ignored and not queued.
  - letter_code is sampled only at acceptance.
  - busy = state in {CLEAR, GLYPH}.
  - vga_plot=0 in IDLE except the registered trailing plot described under GLYPH.

Test Plan:
- Reset: hold reset 2 cycles mid-GLYPH -> next cycle state IDLE, letter_ready=1, vga_plot=0, blk_signal=0, done never pulses.
- Letter E, blk_finished raised after 100 CLEAR cycles:
  - 99 black plots.
  - Exactly 288 plots of colour 111; first at (10,5), last at (29,32).
  - done one cycle after the final position.
- Letter T with blk_finished tied 0:
  - CLEAR lasts exactly 16384 cycles.
  - Then 35*16 glyph cycles with 11*16 = 176 plots, all x in 10..29.
- Space (26) and code 31:
  - Zero foreground plots.
  - done exactly 560 cycles after entering GLYPH.
- letter_valid held high continuously with alternating codes:
  - Only codes sampled while letter_ready=1 are drawn.
  - Each done is followed by exactly one IDLE cycle before the next CLEAR.
- SCALE=1, ORIGIN_X=250:
  - Letter E column 4 pixels land at x = (254) mod 256 = 254.
  - Columns past 255 wrap to 0..; no X or overflow propagation.
